// File: rtl/axis_arbiter.sv
// axis_arbiter: packet-aware round-robin N-to-1 AXI-Stream merger.
// Locks onto one source per packet; registered output with source tid.
module axis_arbiter #(
    parameter int AXIS_BYTES  = 1,
    parameter int NUM_STREAMS = 2,
    localparam int ID_BITS =
        (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic [NUM_STREAMS-1:0]             axis_i_tvalid,
    output logic [NUM_STREAMS-1:0]             axis_i_tready,
    input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic [NUM_STREAMS*AXIS_BYTES-1:0]  axis_i_tkeep,
    input  logic [NUM_STREAMS-1:0]             axis_i_tlast,
    output logic                               axis_o_tvalid,
    input  logic                               axis_o_tready,
    output logic [AXIS_BYTES*8-1:0]            axis_o_tdata,
    output logic [AXIS_BYTES-1:0]              axis_o_tkeep,
    output logic                               axis_o_tlast,
    output logic [ID_BITS-1:0]                 axis_o_tid
);

    localparam int DW = AXIS_BYTES * 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state;
    logic [ID_BITS-1:0] rr;
    logic [ID_BITS-1:0] lock_g;
    logic [ID_BITS-1:0] win;
    logic [ID_BITS-1:0] sel;
    logic [ID_BITS-1:0] nxt_rr;
    logic               found;
    logic               can_load;
    logic               accept;
    logic [DW-1:0]      sel_data;
    logic [AXIS_BYTES-1:0] sel_keep;
    logic               sel_last;
    int                 best_d;
    int                 d;

    // Winner is the valid stream at the smallest rotational distance from rr.
    always_comb begin
        win    = '0;
        found  = 1'b0;
        best_d = NUM_STREAMS;
        d      = 0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            d = (k >= int'(rr)) ? (k - int'(rr))
                                : (k + NUM_STREAMS - int'(rr));
            if (axis_i_tvalid[k] && (d < best_d)) begin
                best_d = d;
                win    = ID_BITS'(k);
                found  = 1'b1;
            end
        end
    end

    assign can_load = !axis_o_tvalid || axis_o_tready;
    assign sel      = (state == LOCKED) ? lock_g : win;
    assign nxt_rr   = (sel == ID_BITS'(NUM_STREAMS - 1)) ? '0
                                                         : sel + 1'b1;

    always_comb begin
        axis_i_tready = '0;
        sel_data      = '0;
        sel_keep      = '0;
        sel_last      = 1'b0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            if (sel == ID_BITS'(k)) begin
                sel_data = axis_i_tdata[k*DW +: DW];
                sel_keep = axis_i_tkeep[k*AXIS_BYTES +: AXIS_BYTES];
                sel_last = axis_i_tlast[k];
            end
            axis_i_tready[k] = !areset && can_load &&
                               (sel == ID_BITS'(k)) &&
                               ((state == LOCKED) || found);
        end
    end

    assign accept = |(axis_i_tvalid & axis_i_tready);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            rr            <= '0;
            lock_g        <= '0;
            axis_o_tvalid <= 1'b0;
            axis_o_tdata  <= '0;
            axis_o_tkeep  <= '0;
            axis_o_tlast  <= 1'b0;
            axis_o_tid    <= '0;
        end else begin
            if (accept) begin
                axis_o_tvalid <= 1'b1;
                axis_o_tdata  <= sel_data;
                axis_o_tkeep  <= sel_keep;
                axis_o_tlast  <= sel_last;
                axis_o_tid    <= sel;
                if (sel_last) begin
                    state <= IDLE;
                    rr    <= nxt_rr;
                end else begin
                    state  <= LOCKED;
                    lock_g <= sel;
                end
            end else if (can_load) begin
                axis_o_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_arbiter.sv
// tb_axis_arbiter: self-checking bench for axis_arbiter at
// NUM_STREAMS = 2, 3 and 4 with table vectors and scoreboards.
`timescale 1ns/1ps
module tb_axis_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- NUM_STREAMS = 2 ----------------
    logic        rst2;
    logic [1:0]  v2, r2, l2, k2;
    logic [15:0] d2;
    logic        ov2, or2, ol2;
    logic [7:0]  od2;
    logic [0:0]  ok2, oid2;

    axis_arbiter #(.AXIS_BYTES(1), .NUM_STREAMS(2)) u2 (
        .clk(clk), .areset(rst2),
        .axis_i_tvalid(v2), .axis_i_tready(r2),
        .axis_i_tdata(d2), .axis_i_tkeep(k2), .axis_i_tlast(l2),
        .axis_o_tvalid(ov2), .axis_o_tready(or2),
        .axis_o_tdata(od2), .axis_o_tkeep(ok2),
        .axis_o_tlast(ol2), .axis_o_tid(oid2)
    );

    // ---------------- NUM_STREAMS = 3 ----------------
    logic        rst3;
    logic [2:0]  v3, r3, l3, k3;
    logic [23:0] d3;
    logic        ov3, or3, ol3;
    logic [7:0]  od3;
    logic [0:0]  ok3;
    logic [1:0]  oid3;

    axis_arbiter #(.AXIS_BYTES(1), .NUM_STREAMS(3)) u3 (
        .clk(clk), .areset(rst3),
        .axis_i_tvalid(v3), .axis_i_tready(r3),
        .axis_i_tdata(d3), .axis_i_tkeep(k3), .axis_i_tlast(l3),
        .axis_o_tvalid(ov3), .axis_o_tready(or3),
        .axis_o_tdata(od3), .axis_o_tkeep(ok3),
        .axis_o_tlast(ol3), .axis_o_tid(oid3)
    );

    // ---------------- NUM_STREAMS = 4 ----------------
    logic        rst4;
    logic [3:0]  v4, r4, l4, k4;
    logic [31:0] d4;
    logic        ov4, or4, ol4;
    logic [7:0]  od4;
    logic [0:0]  ok4;
    logic [1:0]  oid4;

    axis_arbiter #(.AXIS_BYTES(1), .NUM_STREAMS(4)) u4 (
        .clk(clk), .areset(rst4),
        .axis_i_tvalid(v4), .axis_i_tready(r4),
        .axis_i_tdata(d4), .axis_i_tkeep(k4), .axis_i_tlast(l4),
        .axis_o_tvalid(ov4), .axis_o_tready(or4),
        .axis_o_tdata(od4), .axis_o_tkeep(ok4),
        .axis_o_tlast(ol4), .axis_o_tid(oid4)
    );

    // Source queues {last,data} and expected output {tid,last,data}.
    logic [8:0] s2q [2][$];
    logic [9:0] e2q [$];
    int         b2cyc [$];

    task automatic drive2();
        logic [8:0] h;
        for (int k = 0; k < 2; k++) begin
            v2[k] = (s2q[k].size() > 0);
            if (s2q[k].size() > 0) begin
                h = s2q[k][0];
                d2[k*8 +: 8] = h[7:0];
                l2[k] = h[8];
            end
        end
    endtask

    task automatic cyc2();
        logic [9:0] e;
        @(negedge clk);
        if (ov2 && or2) begin
            chk("u2_beat_expected", 32'(e2q.size() > 0), 1);
            if (e2q.size() > 0) begin
                e = e2q.pop_front();
                chk("u2_beat", {oid2, ol2, od2}, e);
                chk("u2_keep", ok2, 1);
            end
            b2cyc.push_back(cyc);
        end
        for (int k = 0; k < 2; k++)
            if (v2[k] && r2[k]) void'(s2q[k].pop_front());
        @(posedge clk);
        #1;
        drive2();
    endtask

    // Table vectors for the 3-stream fairness / wrap sequence.
    typedef struct {
        logic [2:0] v;
        logic [2:0] rdy;
        logic       ov;
        logic [1:0] tid;
    } vec_t;

    vec_t       tbl [15];
    logic [2:0] e3q [$];

    logic [9:0]  s4q [4][$];
    logic [9:0]  e4q [4][$];
    logic [12:0] snap;
    logic [9:0]  h4;
    logic [9:0]  e4;
    logic [3:0]  fired;
    logic [2:0]  e3;
    logic [1:0]  prev_tid;
    logic        stall, prev_open;
    int          pk, plen, nbeats, nout, left, ncyc;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b111, 3'b001, 1'b1, 2'd0};
        tbl[1]  = '{3'b111, 3'b010, 1'b1, 2'd1};
        tbl[2]  = '{3'b111, 3'b100, 1'b1, 2'd2};
        tbl[3]  = '{3'b111, 3'b001, 1'b1, 2'd0};
        tbl[4]  = '{3'b111, 3'b010, 1'b1, 2'd1};
        tbl[5]  = '{3'b111, 3'b100, 1'b1, 2'd2};
        tbl[6]  = '{3'b011, 3'b001, 1'b1, 2'd0};
        tbl[7]  = '{3'b010, 3'b010, 1'b1, 2'd1};
        tbl[8]  = '{3'b100, 3'b100, 1'b1, 2'd2};
        tbl[9]  = '{3'b100, 3'b100, 1'b1, 2'd2};
        tbl[10] = '{3'b000, 3'b000, 1'b0, 2'd0};
        tbl[11] = '{3'b010, 3'b010, 1'b1, 2'd1};
        tbl[12] = '{3'b101, 3'b100, 1'b1, 2'd2};
        tbl[13] = '{3'b001, 3'b001, 1'b1, 2'd0};
        tbl[14] = '{3'b000, 3'b000, 1'b0, 2'd0};

        rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        v2 = 2'b11; d2 = '0; l2 = '0; k2 = 2'b11; or2 = 1'b1;
        v3 = 3'b111; d3 = {8'd2, 8'd1, 8'd0}; l3 = 3'b111;
        k3 = 3'b111; or3 = 1'b1;
        v4 = 4'hf; d4 = '0; l4 = '0; k4 = 4'hf; or4 = 1'b1;

        // Reset state, with inputs valid to show tready is held low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_u2_ovalid", ov2, 0);
        chk("rst_u2_odata", od2, 0);
        chk("rst_u2_okeep", ok2, 0);
        chk("rst_u2_olast", ol2, 0);
        chk("rst_u2_otid", oid2, 0);
        chk("rst_u2_iready", r2, 0);
        chk("rst_u3_iready", r3, 0);
        chk("rst_u4_iready", r4, 0);
        chk("rst_u4_ovalid", ov4, 0);
        @(posedge clk);
        #1;
        v2 = '0; v3 = '0; v4 = '0;
        rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;

        // Basic ordering on the 2-stream instance.
        s2q[0].push_back({1'b0, 8'h10});
        s2q[0].push_back({1'b0, 8'h11});
        s2q[0].push_back({1'b1, 8'h12});
        s2q[1].push_back({1'b0, 8'h20});
        s2q[1].push_back({1'b1, 8'h21});
        e2q.push_back({1'b0, 1'b0, 8'h10});
        e2q.push_back({1'b0, 1'b0, 8'h11});
        e2q.push_back({1'b0, 1'b1, 8'h12});
        e2q.push_back({1'b1, 1'b0, 8'h20});
        e2q.push_back({1'b1, 1'b1, 8'h21});
        drive2();
        repeat (8) cyc2();
        chk("order_left", e2q.size(), 0);
        chk("order_nbeats", b2cyc.size(), 5);
        if (b2cyc.size() == 5) begin
            chk("order_no_bubble", b2cyc[3] - b2cyc[2], 1);
            chk("order_span", b2cyc[4] - b2cyc[0], 4);
        end

        // No preemption: stream 1 stays valid while stream 0 pauses.
        s2q[0].push_back({1'b0, 8'ha0});
        s2q[1].push_back({1'b1, 8'h55});
        e2q.push_back({1'b0, 1'b0, 8'ha0});
        e2q.push_back({1'b0, 1'b1, 8'hb1});
        e2q.push_back({1'b1, 1'b1, 8'h55});
        drive2();
        cyc2();
        repeat (5) begin
            cyc2();
            chk("nopre_r1_low", r2[1], 0);
        end
        s2q[0].push_back({1'b1, 8'hb1});
        drive2();
        repeat (6) cyc2();
        chk("nopre_left", e2q.size(), 0);

        // Fairness and non-power-of-2 wrap on the 3-stream instance.
        for (int i = 0; i < 15; i++) begin
            v3 = tbl[i].v;
            @(negedge clk);
            chk($sformatf("fair_rdy_%0d", i), r3, tbl[i].rdy);
            e3q.push_back({tbl[i].ov, tbl[i].tid});
            @(posedge clk);
            #1;
            e3 = e3q.pop_front();
            chk($sformatf("fair_ov_%0d", i), ov3, e3[2]);
            if (e3[2]) begin
                chk($sformatf("fair_tid_%0d", i), oid3, e3[1:0]);
                chk($sformatf("fair_data_%0d", i), od3, e3[1:0]);
                chk($sformatf("fair_last_%0d", i), ol3, 1);
            end
        end

        // Reset in the middle of a 4-beat packet from stream 2.
        l3 = 3'b000;
        v3 = 3'b100;
        for (int b = 0; b < 2; b++) begin
            d3[23:16] = 8'(8'h30 + b);
            @(negedge clk);
            chk("rstmid_rdy", r3, 3'b100);
            @(posedge clk);
            #1;
        end
        chk("rstmid_beat1", od3, 8'h31);
        d3[23:16] = 8'h32;
        d3[15:8]  = 8'h01;
        l3[1]     = 1'b1;
        v3        = 3'b110;
        #2;
        rst3 = 1'b1;
        #1;
        chk("rstmid_ov_low", ov3, 0);
        chk("rstmid_rdy_low", r3, 0);
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        @(negedge clk);
        chk("rstmid_regrant", r3, 3'b010);
        @(posedge clk);
        #1;
        chk("rstmid_out_tid", oid3, 1);
        chk("rstmid_out_data", od3, 8'h01);
        v3 = '0;

        // Random backpressure over 200 packets from 4 streams.
        nbeats = 0;
        for (int p = 0; p < 200; p++) begin
            pk   = $urandom_range(3, 0);
            plen = $urandom_range(8, 1);
            for (int b = 0; b < plen; b++)
                s4q[pk].push_back({1'($urandom_range(1, 0)),
                                   (b == plen - 1), 8'($urandom)});
            nbeats += plen;
        end
        fired = '0; stall = 1'b0; prev_open = 1'b0; prev_tid = '0;
        nout = 0; ncyc = 0; left = nbeats; snap = '0;
        while ((left > 0) && (ncyc < 20000)) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (fired[k]) v4[k] = 1'b0;
                if (!v4[k] && (s4q[k].size() > 0) &&
                    ($urandom_range(9, 0) < 6))
                    v4[k] = 1'b1;
                if (v4[k]) begin
                    h4 = s4q[k][0];
                    d4[k*8 +: 8] = h4[7:0];
                    l4[k] = h4[8];
                    k4[k] = h4[9];
                end
            end
            or4 = 1'($urandom_range(1, 0));
            @(negedge clk);
            if (stall)
                chk("bp_stable", {ov4, od4, ok4, ol4, oid4}, snap);
            if (ov4 && or4) begin
                nout++;
                if (prev_open) chk("bp_no_interleave", oid4, prev_tid);
                chk("bp_tid_expected", 32'(e4q[oid4].size() > 0), 1);
                if (e4q[oid4].size() > 0) begin
                    e4 = e4q[oid4].pop_front();
                    chk("bp_beat", {ok4, ol4, od4}, e4);
                end
                prev_open = !ol4;
                prev_tid  = oid4;
            end
            stall = ov4 && !or4;
            snap  = {ov4, od4, ok4, ol4, oid4};
            fired = v4 & r4;
            for (int k = 0; k < 4; k++)
                if (fired[k]) e4q[k].push_back(s4q[k].pop_front());
            left = 0;
            for (int k = 0; k < 4; k++)
                left += s4q[k].size() + e4q[k].size();
            ncyc++;
        end
        chk("bp_drain", left, 0);
        chk("bp_count", nout, nbeats);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_arbiter.md
# axis_arbiter

Packet-aware round-robin N-to-1 AXI-Stream merger, the converging counterpart of the 1-to-N stream broadcaster. Selects one of NUM_STREAMS input streams, locks onto it for a whole packet (until the beat carrying tlast), and forwards that packet through a registered output stage with full throughput. A tid sideband tags each output beat with its source index.

## Interface

Parameters:
- AXIS_BYTES, 1, tdata width in bytes; tdata is AXIS_BYTES*8 bits and tkeep is AXIS_BYTES bits.
- NUM_STREAMS, 2, number of input streams; legal range is 1 or more.
- ID_BITS, max(1, $clog2(NUM_STREAMS)), width of axis_o_tid; this is a derived localparam and is not overridable.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk, in, 1, the single clock; all logic is rising-edge.
- areset, in, 1, asynchronous active-high reset; deassertion is synchronous to clk (done externally).
- axis_i_tvalid, in, NUM_STREAMS, per-stream valid; bit k belongs to stream k.
- axis_i_tready, out, NUM_STREAMS, per-stream ready.
- axis_i_tdata, in, NUM_STREAMS*AXIS_BYTES*8, stream k occupies slice [k*AXIS_BYTES*8 +: AXIS_BYTES*8].
- axis_i_tkeep, in, NUM_STREAMS*AXIS_BYTES, stream k occupies slice [k*AXIS_BYTES +: AXIS_BYTES].
- axis_i_tlast, in, NUM_STREAMS, per-stream end of packet.
- axis_o_tvalid, out, 1, merged stream valid (registered).
- axis_o_tready, in, 1, merged stream ready.
- axis_o_tdata, out, AXIS_BYTES*8, registered data.
- axis_o_tkeep, out, AXIS_BYTES, registered keep.
- axis_o_tlast, out, 1, registered last.
- axis_o_tid, out, ID_BITS, index of the stream the beat came from.

## Operation

- Output stage: a single register set holding tvalid, tdata, tkeep, tlast and tid.
  - can_load = !axis_o_tvalid || axis_o_tready.
  - An input beat is accepted when axis_i_tvalid[g] && axis_i_tready[g]. The register then loads the granted slice and tid = g, and axis_o_tvalid = 1.
  - If can_load is true and no beat is accepted, axis_o_tvalid is cleared to 0.
- State machine: two states, IDLE and LOCKED. There is also a registered grant index lock_g and a round-robin pointer rr (range 0..NUM_STREAMS-1).
- IDLE:
  - The combinational winner w is the first k with axis_i_tvalid[k] = 1, searching k = rr, rr+1, … and wrapping modulo NUM_STREAMS.
  - axis_i_tready[w] = can_load; all other bits are 0.
  - If no input is valid, all tready bits are 0.
  - If a beat from w is accepted with tlast = 0: lock_g <= w and the state moves to LOCKED.
  - If a beat from w is accepted with tlast = 1 (single-beat packet): the state stays IDLE and rr <= (w+1) mod NUM_STREAMS.
- LOCKED:
  - axis_i_tready[lock_g] = can_load; all other bits are 0.
  - Other streams are ignored even if lock_g drops tvalid mid-packet. The arbiter waits indefinitely and never preempts.
  - An accepted beat with tlast = 1 moves the state to IDLE and sets rr <= (lock_g+1) mod NUM_STREAMS.
- Data, tkeep and tlast pass through unmodified. tkeep is not interpreted (null beats are forwarded).
- NUM_STREAMS = 1 degenerates to a registered pipeline stage. rr and tid are then constant 0.
- Arithmetic: rr wrap uses an explicit compare against NUM_STREAMS-1, so non-power-of-2 counts wrap correctly.

## Timing

- Reset values:
  - axis_o_tvalid = 0, axis_o_tdata = 0, axis_o_tkeep = 0, axis_o_tlast = 0, axis_o_tid = 0.
  - State = IDLE, rr = 0, lock_g = 0.
  - axis_i_tready = 0 throughout reset.
- Latency: a beat accepted on edge n is visible on axis_o_* after edge n.
- Throughput: 1 beat/cycle when axis_o_tready is held high. Back-to-back packets from different streams have no bubble, because arbitration is combinational in IDLE.
- axis_i_tready depends combinationally on axis_o_tready, state, rr and axis_i_tvalid. Once asserted, axis_i_tvalid must stay asserted until accepted (AXIS rule). The arbiter never withdraws a grant while valid is held.
- axis_o_* is stable while axis_o_tvalid && !axis_o_tready.
- Reset mid-packet: the in-flight output beat is discarded and the lock is released. After reset, arbitration restarts at stream 0; partial-packet recovery belongs to the upstream logic.

## Test plan

- Basic ordering:
  - Stimulus: NUM_STREAMS=2, AXIS_BYTES=1. Stream 0 sends packet {0x10,0x11,0x12(last)} while stream 1 simultaneously sends {0x20,0x21(last)}, and axis_o_tready is held 1.
  - Required: the output is 0x10,0x11,0x12,0x20,0x21 with tid 0,0,0,1,1, tlast on 0x12 and 0x21, and no idle cycle between 0x12 and 0x20.
- Fairness:
  - Stimulus: NUM_STREAMS=3, all streams continuously offer single-beat packets with data = stream index.
  - Required: tid sequence 0,1,2,0,1,2…
- No preemption:
  - Stimulus: stream 1 holds tvalid=1 constantly. Stream 0 sends beat A (no tlast), deasserts valid for 5 cycles, then sends B (last).
  - Required: the output is A then B with tid 0, and no stream-1 beat appears between them.
- Backpressure:
  - Stimulus: random axis_o_tready (50%) over 200 packets from 4 streams with random lengths 1–8.
  - Required: each stream's packets arrive intact and in order, tid matches the source, and output data is stable while stalled.
- Reset mid-packet:
  - Stimulus: assert areset asynchronously during beat 2 of a 4-beat packet.
  - Required: axis_o_tvalid and all axis_i_tready go 0 immediately. After release, the first grant goes to the lowest-index valid stream.
- Non-power-of-2 wrap:
  - Stimulus: NUM_STREAMS=3, only stream 2 is active.
  - Required: rr wraps from 2 to 0 with no X or out-of-range grant.
